// File: rtl/btn_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the push-button conditioner:
//     - per-channel FSM state encoding (IDLE / DLY / RPT, 2'd3 unused)
//     - default timing constants for a 12 MHz clock
//     - channel index constants into the 3-bit held vector
//     - helper functions for sizing the shared counter width
// -----------------------------------------------------------------------------
package btn_pkg;

  // Auto-repeat FSM encoding. 2'd3 is never produced and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DLY  = 2'd1,
    RPT  = 2'd2
  } ch_state_t;

  // Defaults for a 12 MHz clock: 1 ms debounce, 0.5 s first repeat,
  // 0.1 s repeat period.
  localparam int DEF_DB_CYCLES     = 12000;
  localparam int DEF_REPEAT_DELAY  = 6000000;
  localparam int DEF_REPEAT_PERIOD = 1200000;

  // Bit positions inside held = {ok, up, down}.
  localparam int DOWN = 0;
  localparam int UP   = 1;
  localparam int OK   = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One width covers the debounce counter and the repeat timer.
  function automatic int cnt_width(input int db, input int dly, input int per);
    return $clog2(max3(db, dly, per) + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// btn_debounce_ch
//   One push-button channel: 2-flop synchroniser, counter-based debouncer,
//   registered rising-edge pulse and (when REPEAT_EN=1) an auto-repeat FSM.
//
//   Ports:
//     clk       system clock
//     rst       asynchronous reset, active-low
//     raw       raw button level, pressed = 1, asynchronous to clk
//     hold_rpt  freeze the repeat timer (both up and down are held)
//     pulse     one-cycle pulse per press, plus repeats when enabled
//     level     debounced stable level
//
//   The FSM state lives in state_q (type ch_state_t) as the single
//   observation point for the channel's repeat behaviour.
// -----------------------------------------------------------------------------
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int REPEAT_EN     = 1,
  parameter int CW            = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic hold_rpt,
  output logic pulse,
  output logic level
);

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LOAD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LOAD = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_dly_q;
  logic [CW-1:0] db_cnt_q;
  logic          rise;

  ch_state_t     state_q;
  ch_state_t     state_nxt;
  logic [CW-1:0] timer_q;
  logic [CW-1:0] timer_nxt;
  logic          timer_zero;
  logic          pulse_nxt;

  // Synchroniser: only sync2_q is used downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the stable level follows the synced input only after
  // DB_CYCLES consecutive cycles of disagreement; any agreement restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else if (sync2_q == stable_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_q <= sync2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + CNT_ONE;
    end
  end

  // Delayed copy for rise detection; the pulse register adds one more cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_dly_q <= 1'b0;
    end else begin
      stable_dly_q <= stable_q;
    end
  end

  assign rise       = stable_q & ~stable_dly_q;
  assign level      = stable_q;
  assign timer_zero = (timer_q == '0);

  // FSM state register (state + repeat timer).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
    end
  end

  // FSM next state. Release wins over everything; while hold_rpt is set
  // the timer keeps its value so it resumes where it stopped.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    case (state_q)
      IDLE: begin
        if (rise && (REPEAT_EN != 0)) begin
          state_nxt = DLY;
          timer_nxt = DLY_LOAD;
        end
      end
      DLY, RPT: begin
        if (!stable_q) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (!hold_rpt) begin
          if (timer_zero) begin
            state_nxt = RPT;
            timer_nxt = PER_LOAD;
          end else begin
            timer_nxt = timer_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // FSM output: press pulse from IDLE, repeat pulse on timer expiry.
  always_comb begin
    pulse_nxt = 1'b0;
    case (state_q)
      IDLE:     pulse_nxt = rise;
      DLY, RPT: pulse_nxt = stable_q & ~hold_rpt & timer_zero;
      default:  pulse_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse <= 1'b0;
    end else begin
      pulse <= pulse_nxt;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// btn_conditioner
//   Input stage for divisor_4b: synchronises and debounces the three raw
//   push-buttons and emits one-cycle pulses per press. up/down auto-repeat
//   while held; ok never repeats.
//
//   Ports:
//     clk       system clock
//     rst       asynchronous reset, active-low
//     down_raw  raw button, pressed = 1
//     up_raw    raw button, pressed = 1
//     ok_raw    raw button, pressed = 1
//     down      one-cycle press/repeat pulse
//     up        one-cycle press/repeat pulse
//     ok        one-cycle press pulse
//     held      debounced levels {ok, up, down}
// -----------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       down_raw,
  input  logic       up_raw,
  input  logic       ok_raw,
  output logic       down,
  output logic       up,
  output logic       ok,
  output logic [2:0] held
);

  localparam int CW = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  logic [2:0] level;
  logic       hold_rpt;

  // Holding up and down together freezes both repeat timers.
  assign hold_rpt = level[UP] & level[DOWN];
  assign held     = level;

  btn_debounce_ch #(
    .DB_CYCLES     (DB_CYCLES),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .REPEAT_EN     (1),
    .CW            (CW)
  ) u_down (
    .clk      (clk),
    .rst      (rst),
    .raw      (down_raw),
    .hold_rpt (hold_rpt),
    .pulse    (down),
    .level    (level[DOWN])
  );

  btn_debounce_ch #(
    .DB_CYCLES     (DB_CYCLES),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .REPEAT_EN     (1),
    .CW            (CW)
  ) u_up (
    .clk      (clk),
    .rst      (rst),
    .raw      (up_raw),
    .hold_rpt (hold_rpt),
    .pulse    (up),
    .level    (level[UP])
  );

  btn_debounce_ch #(
    .DB_CYCLES     (DB_CYCLES),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .REPEAT_EN     (0),
    .CW            (CW)
  ) u_ok (
    .clk      (clk),
    .rst      (rst),
    .raw      (ok_raw),
    .hold_rpt (hold_rpt),
    .pulse    (ok),
    .level    (level[OK])
  );

endmodule

// File: tb/tb_btn_conditioner.sv
`timescale 1ns/1ps
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       down_raw = 1'b0;
  logic       up_raw = 1'b0;
  logic       ok_raw = 1'b0;
  logic       down;
  logic       up;
  logic       ok;
  logic [2:0] held;

  int errors = 0;
  int checks = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  btn_conditioner #(
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .down_raw (down_raw),
    .up_raw   (up_raw),
    .ok_raw   (ok_raw),
    .down     (down),
    .up       (up),
    .ok       (ok),
    .held     (held)
  );

  // ---------------- vector table ----------------
  // raw / exp_pls / exp_held bit order: {ok, up, down}
  typedef struct {
    logic       rst;
    logic [2:0] raw;
    logic [2:0] exp_pls;
    logic [2:0] exp_held;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] raw,
                     input logic [2:0] pls, input logic [2:0] hld);
    vec_t v;
    v.rst      = r;
    v.raw      = raw;
    v.exp_pls  = pls;
    v.exp_held = hld;
    vecs.push_back(v);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 3'b000, 3'b000, 3'b000);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check3(input string name, input int idx,
                        input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic compare_queues(input string name);
    check_int({name, " count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check_int({name, " cycle"}, int'(got_q.pop_front()), int'(exp_q.pop_front()));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic       r;
    logic [5:0] bounce;
    int         first;

    // Reset with all buttons pressed, then release: all three pulse at
    // edge 7; up/down both held so no repeats appear.
    for (int i = 0; i < 3; i++) add(1'b0, 3'b111, 3'b000, 3'b000);
    for (int k = 1; k <= 20; k++)
      add(1'b1, 3'b111, (k == 7) ? 3'b111 : 3'b000, (k >= 6) ? 3'b111 : 3'b000);

    // Clean ok press for 20 cycles; held falls at edge 26, no release pulse.
    add_reset(2);
    for (int k = 1; k <= 30; k++)
      add(1'b1, {(k <= 20), 2'b00}, {(k == 7), 2'b00}, {(k >= 6 && k < 26), 2'b00});

    // Bouncing up press 1,0,1,1,0,1 then steady: single pulse at edge 12.
    add_reset(2);
    bounce = 6'b101101;  // bounce[0] is the first applied cycle
    for (int k = 1; k <= 20; k++) begin
      r = (k <= 6) ? bounce[k-1] : 1'b1;
      add(1'b1, {1'b0, r, 1'b0}, {1'b0, (k == 12), 1'b0}, {1'b0, (k >= 11), 1'b0});
    end

    // 3-cycle glitch on up: nothing at all.
    add_reset(2);
    for (int k = 1; k <= 12; k++)
      add(1'b1, {1'b0, (k <= 3), 1'b0}, 3'b000, 3'b000);

    // down and ok held 40 cycles: down repeats at 17,22,...,42; ok once.
    add_reset(2);
    for (int k = 1; k <= 55; k++)
      add(1'b1, {(k <= 40), 1'b0, (k <= 40)},
          {(k == 7), 1'b0, (k inside {7, 17, 22, 27, 32, 37, 42})},
          {(k >= 6 && k < 46), 1'b0, (k >= 6 && k < 46)});

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      {ok_raw, up_raw, down_raw} = vecs[i].raw;
      step();
      check3("vec pulse", i, {ok, up, down}, vecs[i].exp_pls);
      check3("vec held", i, held, vecs[i].exp_held);
    end

    // Simultaneous up+down, down released before edge 13: down held falls
    // at edge 18, up timer resumes from 9 and fires at 28, then every 5.
    rst = 1'b0; up_raw = 1'b0; down_raw = 1'b0; ok_raw = 1'b0;
    step(); step();
    rst = 1'b1; up_raw = 1'b1; down_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 13) down_raw = 1'b0;
      step();
      if (up) got_q.push_back(8'(k));
    end
    exp_q = '{8'd7, 8'd28, 8'd33, 8'd38};
    compare_queues("simul up");

    rst = 1'b0; up_raw = 1'b0; down_raw = 1'b0;
    step(); step();
    rst = 1'b1; up_raw = 1'b1; down_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 13) down_raw = 1'b0;
      step();
      if (down) got_q.push_back(8'(k));
    end
    exp_q = '{8'd7};
    compare_queues("simul down");

    // Reset while up is in RPT, exactly on a repeat pulse (edge 22).
    rst = 1'b0; up_raw = 1'b0; down_raw = 1'b0;
    step(); step();
    rst = 1'b1; up_raw = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (up) got_q.push_back(8'(k));
    end
    exp_q = '{8'd7, 8'd17, 8'd22};
    compare_queues("pre-reset up");
    rst = 1'b0;
    #1;
    check_int("async reset up", int'(up), 0);
    check_int("async reset held", int'(held), 0);
    step();
    check_int("in reset up", int'(up), 0);
    check_int("in reset held", int'(held), 0);
    step();
    rst = 1'b1;
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 6) check_int("post-reset held", int'(held), 3'b010);
      if (up && first < 0) first = n;
    end
    check_int("post-reset first up pulse edge", first, 7);

    up_raw = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for divisor_4b.
- Takes the three raw push-buttons (down, up, ok) from the board and synchronises and debounces each one.
- Emits a clean single-cycle pulse per press on the down/up/ok lines that divisor_4b consumes.
- up/down additionally auto-repeat while held, so a value can be ramped by holding a key.

Parameters:
- DB_CYCLES, 12000, consecutive stable cycles needed to accept a level change (1 ms at 12 MHz); must be >= 2.
- REPEAT_DELAY, 6000000, cycles from the press pulse to the first auto-repeat pulse (0.5 s).
- REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeat pulses (0.1 s); must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- down_raw  in  1  raw button, pressed = 1, asynchronous to clk
- up_raw  in  1  raw button, pressed = 1, asynchronous to clk
- ok_raw  in  1  raw button, pressed = 1, asynchronous to clk
- down  out  1  one-cycle press/repeat pulse to divisor_4b
- up  out  1  one-cycle press/repeat pulse to divisor_4b
- ok  out  1  one-cycle press pulse to divisor_4b (never repeats)
- held  out  3  debounced levels {ok, up, down}

Behaviour:
- Reset:
  - rst low clears every flop asynchronously: sync stages, stable levels, counters, FSMs.
  - down, up, ok and held are all 0 while rst is low and on the first edge after release.
- Synchronisation: each raw input passes through a 2-flop synchroniser reset to 0; only the second flop is used downstream.
- Debounce, per channel:
  - Keep a stable level S and a counter C.
  - If sync == S: C <= 0.
  - Else if C == DB_CYCLES-1: S <= sync, C <= 0.
  - Else: C <= C+1.
  - So S changes only after DB_CYCLES consecutive cycles of disagreement. Any glitch shorter than that resets C and produces nothing.
  - held[i] = S.
- Pulse timing:
  - The pulse is registered and fires on the cycle after S rises 0->1.
  - Latency from the first clk edge sampling raw=1 to the pulse being high is DB_CYCLES+3 edges (2 sync + DB_CYCLES + 1).
  - Release (S falling) produces no pulse.
- Channel FSM (up and down only):
  - IDLE -> DLY on S rise: emit pulse, load timer T = REPEAT_DELAY-1.
  - DLY: decrement T while S=1. At T==0 emit pulse, T <= REPEAT_PERIOD-1, go to RPT.
  - RPT: decrement T while S=1. At T==0 emit pulse, reload T <= REPEAT_PERIOD-1.
  - DLY/RPT -> IDLE on S=0, with no pulse on that cycle.
- ok channel: has only the rise-pulse path and no timer; it never repeats.
- Pulse period: repeat pulses are exactly REPEAT_PERIOD cycles apart. The first repeat pulse is exactly REPEAT_DELAY cycles after the press pulse.
- Simultaneous up+down:
  - Each rise pulse is still emitted independently, so both can pulse on the same cycle.
  - While both held are 1, both timers are held (no decrement, no repeat pulses).
  - Decrementing resumes from the held value when one is released.
- ok is independent of up/down in all cases.
- Reset mid-operation: all state returns to IDLE and outputs drop immediately. A button still held when rst rises is treated as a new press: one pulse after DB_CYCLES+3 edges.
- Widths:
  - Counter width = $clog2(max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1).
  - Counters never wrap, because they are reloaded or cleared before reaching the limit.

Decomposition:
- Shared package btn_pkg:
  - FSM state encoding: IDLE=2'd0, DLY=2'd1, RPT=2'd2; unused 2'd3 goes to IDLE.
  - Default timing constants.
  - Channel index constants: DOWN=0, UP=1, OK=2.
- Sub-module btn_debounce_ch:
  - Contains the sync, debounce, pulse and FSM for one channel.
  - Parameter REPEAT_EN (1 for up/down, 0 for ok).
  - Input hold_rpt, driven by the top as held[UP]&held[DOWN].
  - The top instantiates it three times.

Test Plan (sim parameters DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5):
- Reset: rst=0 for 3 cycles with all raw inputs=1 -> down/up/ok/held = 0 throughout. Release rst -> ok pulses exactly once, 7 edges after release, with held=3'b111; up/down behave likewise.
- Clean press: ok_raw=1 for 20 cycles then 0 -> single ok pulse, high exactly 1 cycle, 7 edges after the rise. No pulse on release. held[2] falls 4 cycles after the synced fall.
- Bounce: up_raw toggles 1,0,1,1,0,1 at 1-cycle intervals, then stays 1 -> exactly one up pulse, 7 edges after the final rise. A 3-cycle high glitch yields no pulse and held stays 0.
- Auto-repeat: down_raw held for 40 cycles -> down pulses at press pulse P, P+10, P+15, P+20, ... stopping on release. ok held 40 cycles -> one pulse only.
- Simultaneous: up and down pressed together -> both pulse on the same cycle and no repeats while both are held. Release down at P+6 -> up repeat resumes and pulses at P+10 plus the number of cycles both were held beyond P.
- Reset mid-repeat: rst=0 during the RPT state of up -> up=0 and held=0 immediately. The next pulse comes only after rst rises plus 7 edges, if still held.
